alu_sequencer: RTL
==================

# alu_sequencer

Execution sequencer that sits directly upstream of the ALU. It accepts one encoded instruction at a time over a valid/ready handshake and reads operands from its own 4×8-bit register file. It then drives the ALU's operand buses and its one-hot operation strobes for exactly one cycle, captures the ALU's registered result and writes it back to the destination register. Status flags and a done pulse report completion to the control unit.

## Interface
- No parameters; register file fixed at 4 entries × 8 bits.
- clock  in  1  sole clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- instr_valid  in  1  instruction present
- instr_ready  out  1  sequencer can accept (high only in IDLE, low while reset asserted)
- instr  in  11  [10:7] opcode, [6] dir (0=LEFT, 1=RIGHT), [5:4] dst, [3:2] src_a, [1:0] src_b
- reg_we / reg_waddr / reg_wdata  in  1/2/8  external register load
- rd_addr  in  2  debug read address; rd_data  out  8  combinational register-file read
- done  out  1  one-cycle completion pulse
- zero  out  1  last executed result was 0x00
- err_div0, err_illegal  out  1 each  sticky error flags
- err_clear  in  1  clears both error flags
- register1, register2  out  8 each  to ALU operands
- out  out  1  ALU enable
- op_add, op_sub, op_mul, op_div, op_shift, op_rot, op_and, op_or, op_xor, op_not  out  1 each  ALU strobes
- op_dir  out  op_dir_e  ALU direction (LEFT/RIGHT)
- alu_result  in  8  ALU registered result

## Operation
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 SHIFT, 6 ROT, 7 AND, 8 OR, 9 XOR, 10 NOT, 11–15 illegal.
- The FSM has four states: IDLE, ISSUE, CAPTURE and DONE.
- IDLE: instr_ready=1. An instruction is accepted on a posedge with instr_valid && instr_ready. At acceptance, instr is latched.
- Routing from IDLE on acceptance:
  - Opcodes 1–10 go to ISSUE.
  - NOP, an illegal opcode, or DIV whose src_b register reads 0x00 goes directly to DONE.
  - Illegal sets err_illegal. DIV-by-zero sets err_div0.
  - None of these writes a register or asserts out.
- ISSUE (1 cycle):
  - out=1; exactly one strobe high per opcode; op_dir from the latched dir.
  - register1 = regfile[src_a].
  - register2 = regfile[src_b] for binary ops, 0x00 for SHIFT/ROT/NOT.
  - Next state is CAPTURE.
- CAPTURE (1 cycle): regfile[dst] ← alu_result at the closing posedge. Next state is DONE.
- DONE (1 cycle):
  - done=1.
  - For executed ops, zero ← (regfile[dst]==0x00). zero is unchanged for skipped ops.
  - Next state is IDLE.
- Outside ISSUE: out=0, all strobes 0, register1=register2=0x00, op_dir=LEFT.
- External load is honoured only in IDLE: regfile[reg_waddr] ← reg_wdata. A load in the same cycle as an acceptance takes effect, and the accepted instruction sees the new value, because operands are read in ISSUE. The DIV-by-zero check also uses the post-load value. reg_we outside IDLE is ignored.
- err_clear clears both error flags. If a new error sets in the same cycle, set wins.
- Arithmetic is the ALU's, not recomputed here: 8-bit modular ADD/SUB, MUL keeps the low 8 bits. dst may equal src_a/src_b; operands are already consumed in ISSUE.

## Timing
- Reset values:
  - state IDLE, all regfile entries 0x00.
  - done=0, zero=0, err_div0=0, err_illegal=0.
  - out=0, all strobes 0, register1=register2=0x00, op_dir=LEFT.
- Executed op: accept at edge E0; ISSUE in cycle E0–E1; ALU samples at E1; CAPTURE writes at E2; done high in cycle E2–E3; instr_ready high again after E3. Throughput is one instruction per 4 cycles.
- Skipped op: accept at E0; done high in cycle E0–E1; ready after E1.
- instr is ignored while instr_ready=0. Holding instr_valid high yields back-to-back acceptance at every IDLE cycle.
- Reset asserted mid-operation aborts immediately: no writeback, no done, all registers cleared. instr_ready is low during reset and high the first cycle after deassertion.

## Test plan
- Load r0=0x07, r1=0x05; ADD dst=r2 → register1=0x07, register2=0x05, out=1 and op_add=1 for exactly 1 cycle; r2=0x0C; done 3 cycles after accept; zero=0.
- Load r0=0x80, r1=0x80; SUB dst=r3, then MUL dst=r2 → r3=0x00 with zero=1; r2=0x00 (truncated); strobes one-hot each time.
- r1=0x00; DIV src_b=r1 → out never asserted, err_div0=1, done the cycle after accept, dst unchanged; err_clear → err_div0=0.
- Opcode 13 → err_illegal=1, no register change, done after 1 cycle; NOP → done, no flags.
- ROT dir=RIGHT on r0=0x01 → op_dir=RIGHT, register2=0x00, r0=0x80; reg_we while state≠IDLE → no effect.
- Assert reset during CAPTURE of ADD → no done, all registers 0x00, instr_ready=1 the first cycle after release.

Source files
------------

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - instruction sequencer feeding a registered ALU from a 4x8 register file

package alu_sequencer_pkg;
    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } op_dir_e;
endpackage

module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [10:0] instr,
    input  logic        reg_we,
    input  logic [1:0]  reg_waddr,
    input  logic [7:0]  reg_wdata,
    input  logic [1:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        done,
    output logic        zero,
    output logic        err_div0,
    output logic        err_illegal,
    input  logic        err_clear,
    output logic [7:0]  register1,
    output logic [7:0]  register2,
    output logic        out,
    output logic        op_add,
    output logic        op_sub,
    output logic        op_mul,
    output logic        op_div,
    output logic        op_shift,
    output logic        op_rot,
    output logic        op_and,
    output logic        op_or,
    output logic        op_xor,
    output logic        op_not,
    output op_dir_e     op_dir,
    input  logic [7:0]  alu_result
);

    localparam logic [3:0] OPC_NOP   = 4'd0;
    localparam logic [3:0] OPC_ADD   = 4'd1;
    localparam logic [3:0] OPC_SUB   = 4'd2;
    localparam logic [3:0] OPC_MUL   = 4'd3;
    localparam logic [3:0] OPC_DIV   = 4'd4;
    localparam logic [3:0] OPC_SHIFT = 4'd5;
    localparam logic [3:0] OPC_ROT   = 4'd6;
    localparam logic [3:0] OPC_AND   = 4'd7;
    localparam logic [3:0] OPC_OR    = 4'd8;
    localparam logic [3:0] OPC_XOR   = 4'd9;
    localparam logic [3:0] OPC_NOT   = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] instr_q, instr_d;
    logic        exec_q, exec_d;
    logic [7:0]  regfile_q [4];
    logic [7:0]  regfile_d [4];
    logic        zero_q, zero_d;
    logic        err_div0_q, err_div0_d;
    logic        err_illegal_q, err_illegal_d;

    logic [3:0]  opc_in;
    logic [7:0]  src_b_val_in;
    logic        accept;
    logic        illegal_in;
    logic        div0_in;
    logic        skip_in;

    logic [3:0]  opc_q;
    logic [1:0]  dst_q;
    logic [1:0]  src_a_q;
    logic [1:0]  src_b_q;

    assign opc_q   = instr_q[10:7];
    assign dst_q   = instr_q[5:4];
    assign src_a_q = instr_q[3:2];
    assign src_b_q = instr_q[1:0];

    assign rd_data     = regfile_q[rd_addr];
    assign zero        = zero_q;
    assign err_div0    = err_div0_q;
    assign err_illegal = err_illegal_q;

    // The divide-by-zero check must see a load landing in the same cycle as the accept.
    assign opc_in       = instr[10:7];
    assign src_b_val_in = (reg_we && (reg_waddr == instr[1:0])) ? reg_wdata : regfile_q[instr[1:0]];
    assign illegal_in   = (opc_in > OPC_NOT);
    assign div0_in      = (opc_in == OPC_DIV) && (src_b_val_in == 8'h00);
    assign skip_in      = (opc_in == OPC_NOP) || illegal_in || div0_in;
    assign accept       = instr_valid && instr_ready;

    // Control path: state transitions and ALU-facing outputs.
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        done        = 1'b0;
        out         = 1'b0;
        op_add      = 1'b0;
        op_sub      = 1'b0;
        op_mul      = 1'b0;
        op_div      = 1'b0;
        op_shift    = 1'b0;
        op_rot      = 1'b0;
        op_and      = 1'b0;
        op_or       = 1'b0;
        op_xor      = 1'b0;
        op_not      = 1'b0;
        register1   = 8'h00;
        register2   = 8'h00;
        op_dir      = LEFT;
        case (state_q)
            S_IDLE: begin
                instr_ready = !reset;
                if (accept) begin
                    state_d = skip_in ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                out       = 1'b1;
                op_dir    = op_dir_e'(instr_q[6]);
                register1 = regfile_q[src_a_q];
                register2 = regfile_q[src_b_q];
                case (opc_q)
                    OPC_ADD:   op_add   = 1'b1;
                    OPC_SUB:   op_sub   = 1'b1;
                    OPC_MUL:   op_mul   = 1'b1;
                    OPC_DIV:   op_div   = 1'b1;
                    OPC_SHIFT: op_shift = 1'b1;
                    OPC_ROT:   op_rot   = 1'b1;
                    OPC_AND:   op_and   = 1'b1;
                    OPC_OR:    op_or    = 1'b1;
                    OPC_XOR:   op_xor   = 1'b1;
                    OPC_NOT:   op_not   = 1'b1;
                    default:   out      = 1'b0;
                endcase
                // Unary operations present a clean zero on the second operand bus.
                if ((opc_q == OPC_SHIFT) || (opc_q == OPC_ROT) || (opc_q == OPC_NOT)) begin
                    register2 = 8'h00;
                end
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Data path: instruction latch, register file, status flags.
    always_comb begin
        instr_d       = instr_q;
        exec_d        = exec_q;
        zero_d        = zero_q;
        err_div0_d    = err_div0_q  && !err_clear;
        err_illegal_d = err_illegal_q && !err_clear;
        for (int i = 0; i < 4; i++) begin
            regfile_d[i] = regfile_q[i];
        end
        case (state_q)
            S_IDLE: begin
                if (reg_we) begin
                    regfile_d[reg_waddr] = reg_wdata;
                end
                if (accept) begin
                    instr_d = instr;
                    exec_d  = !skip_in;
                    if (illegal_in) begin
                        err_illegal_d = 1'b1;
                    end
                    if (div0_in) begin
                        err_div0_d = 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                regfile_d[dst_q] = alu_result;
            end
            S_DONE: begin
                if (exec_q) begin
                    zero_d = (regfile_q[dst_q] == 8'h00);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_q       <= 11'd0;
            exec_q        <= 1'b0;
            zero_q        <= 1'b0;
            err_div0_q    <= 1'b0;
            err_illegal_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regfile_q[i] <= 8'h00;
            end
        end else begin
            instr_q       <= instr_d;
            exec_q        <= exec_d;
            zero_q        <= zero_d;
            err_div0_q    <= err_div0_d;
            err_illegal_q <= err_illegal_d;
            for (int i = 0; i < 4; i++) begin
                regfile_q[i] <= regfile_d[i];
            end
        end
    end

endmodule
